// File: rtl/unified_mem_responder_if.sv
// Request/grant/rvalid bus between the fetch + LSU initiators and the unified memory responder.
interface unified_mem_responder_if;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_rvalid_op;
  logic [31:0] instr_rdata_op;
  logic        data_req_ip;
  logic        data_we_ip;
  logic [3:0]  data_be_ip;
  logic [31:0] data_addr_ip;
  logic [31:0] data_wdata_ip;
  logic        data_gnt_op;
  logic        data_rvalid_op;
  logic [31:0] data_rdata_op;
  logic        err_op;
  logic        busy_op;

  modport slave (
    input  instr_req_ip, instr_addr_ip,
    input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
    output instr_gnt_op, instr_rvalid_op, instr_rdata_op,
    output data_gnt_op, data_rvalid_op, data_rdata_op, err_op, busy_op
  );

  modport master (
    output instr_req_ip, instr_addr_ip,
    output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
    input  instr_gnt_op, instr_rvalid_op, instr_rdata_op,
    input  data_gnt_op, data_rvalid_op, data_rdata_op, err_op, busy_op
  );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-ported memory responder shared round-robin by fetch and LSU, fixed LATENCY responses.
// Optional access counters: define MEM_ACCESS_COUNTERS_EN.
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic mem_en,
  unified_mem_responder_if.slave bus
`ifdef MEM_ACCESS_COUNTERS_EN
  ,
  output logic [31:0] instr_access_cnt_op,
  output logic [31:0] data_read_cnt_op,
  output logic [31:0] data_write_cnt_op,
  output logic [31:0] err_cnt_op
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_count, w_count_nxt;
  logic            r_last_data;
  logic            r_port_data;
  logic            r_we;
  logic            r_err;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_grant;
  logic            w_pick_data;
  logic [31:0]     w_addr_in;
  logic            w_err_in;
  logic            w_resp;
  logic [31:0]     w_rdata;

  // Data wins a tie unless it won the previous grant.
  always_comb begin
    w_pick_data = bus.data_req_ip && (!bus.instr_req_ip || !r_last_data);
    w_grant     = !reset && mem_en && (r_state == S_IDLE) &&
                  (bus.instr_req_ip || bus.data_req_ip);
    w_addr_in   = w_pick_data ? bus.data_addr_ip : bus.instr_addr_ip;
    w_err_in    = (w_addr_in[1:0] != 2'b00) || (w_addr_in[31:AW+2] != '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE: if (w_grant) begin
        w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        w_count_nxt = 4'(LATENCY - 1);
      end
      S_WAIT: begin
        w_count_nxt = r_count - 4'd1;
        if (r_count == 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_resp               = !reset && (r_state == S_RESP);
    w_rdata              = (r_err || r_we) ? 32'd0 : r_mem[r_idx];
    bus.instr_gnt_op     = w_grant && !w_pick_data;
    bus.data_gnt_op      = w_grant && w_pick_data;
    bus.instr_rvalid_op  = w_resp && !r_port_data;
    bus.data_rvalid_op   = w_resp && r_port_data;
    bus.instr_rdata_op   = (w_resp && !r_port_data) ? w_rdata : 32'd0;
    bus.data_rdata_op    = (w_resp && r_port_data) ? w_rdata : 32'd0;
    bus.err_op           = w_resp && r_err;
    bus.busy_op          = !reset && ((r_state != S_IDLE) || w_grant);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_last_data <= 1'b0;
      r_port_data <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_be        <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_grant) begin
        r_last_data <= w_pick_data;
        r_port_data <= w_pick_data;
        r_we        <= w_pick_data && bus.data_we_ip;
        r_be        <= bus.data_be_ip;
        r_idx       <= w_addr_in[AW+1:2];
        r_wdata     <= bus.data_wdata_ip;
        r_err       <= w_err_in;
      end
    end
  end

  // Write lands on the edge that ends RESP, so a reset during the transaction drops it.
  always_ff @(posedge clock) begin
    if (!reset && (r_state == S_RESP) && r_we && !r_err) begin
      for (int b = 0; b < 4; b++)
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

`ifdef MEM_ACCESS_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_access_cnt_op <= '0;
      data_read_cnt_op    <= '0;
      data_write_cnt_op   <= '0;
      err_cnt_op          <= '0;
    end else if (r_state == S_RESP) begin
      if (!r_port_data)         instr_access_cnt_op <= instr_access_cnt_op + 32'd1;
      if (r_port_data && !r_we) data_read_cnt_op    <= data_read_cnt_op + 32'd1;
      if (r_port_data && r_we)  data_write_cnt_op   <= data_write_cnt_op + 32'd1;
      if (r_err)                err_cnt_op          <= err_cnt_op + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: transaction-level model checked every cycle plus literal checks.
module tb_unified_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_en = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unified_mem_responder_if bus();
  assign bus.instr_req_ip  = i_req;
  assign bus.instr_addr_ip = i_addr;
  assign bus.data_req_ip   = d_req;
  assign bus.data_we_ip    = d_we;
  assign bus.data_be_ip    = d_be;
  assign bus.data_addr_ip  = d_addr;
  assign bus.data_wdata_ip = d_wdata;

`ifdef MEM_ACCESS_COUNTERS_EN
  logic [31:0] c_instr, c_rd, c_wr, c_err;
`endif

  unified_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock(clk),
    .reset(reset),
    .mem_en(mem_en),
    .bus(bus)
`ifdef MEM_ACCESS_COUNTERS_EN
    , .instr_access_cnt_op(c_instr),
    .data_read_cnt_op(c_rd),
    .data_write_cnt_op(c_wr),
    .err_cnt_op(c_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, response LAT cycles after its grant.
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_kn  [DEPTH];
  bit          m_pend = 0, m_last_data = 0, m_port = 0, m_we = 0, m_err = 0;
  logic [3:0]  m_be;
  logic [31:0] m_wd;
  int          m_idx = 0, m_cyc = 0, m_resp = 0;

  initial for (int i = 0; i < DEPTH; i++) m_kn[i] = 4'h0;

  always @(negedge clk) begin : model
    logic e_ig, e_dg, e_ir, e_dr, e_er, e_by;
    logic [31:0] e_rd, msk, a;
    bit pick_d;
    e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_er = 0; e_by = 0;
    e_rd = '0; msk = '1;
    m_cyc++;
    if (reset) begin
      m_pend = 0;
      m_last_data = 0;
    end else begin
      e_by = m_pend;
      if (m_pend && m_cyc == m_resp) begin
        e_er = m_err;
        if (m_port) e_dr = 1; else e_ir = 1;
        if (!m_err && !m_we) begin
          e_rd = m_mem[m_idx];
          for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{m_kn[m_idx][b]}};
        end
        if (!m_err && m_we)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) begin
              m_mem[m_idx][8*b +: 8] = m_wd[8*b +: 8];
              m_kn[m_idx][b] = 1'b1;
            end
        m_pend = 0;
      end else if (!m_pend && mem_en && (i_req || d_req)) begin
        pick_d = d_req && !(i_req && m_last_data);
        if (pick_d) e_dg = 1; else e_ig = 1;
        a      = pick_d ? d_addr : i_addr;
        m_port = pick_d;
        m_we   = pick_d && d_we;
        m_be   = d_be;
        m_wd   = d_wdata;
        m_err  = (a % 4 != 0) || (a >= 4 * DEPTH);
        m_idx  = (a / 4) % DEPTH;
        m_resp = m_cyc + LAT;
        m_pend = 1;
        m_last_data = pick_d;
        e_by = 1;
      end
    end
    chk("instr_gnt", bus.instr_gnt_op, e_ig);
    chk("data_gnt", bus.data_gnt_op, e_dg);
    chk("instr_rvalid", bus.instr_rvalid_op, e_ir);
    chk("data_rvalid", bus.data_rvalid_op, e_dr);
    chk("err", bus.err_op, e_er);
    chk("busy", bus.busy_op, e_by);
    chk("instr_rdata", bus.instr_rdata_op & (e_ir ? msk : 32'hFFFF_FFFF), e_ir ? (e_rd & msk) : 32'd0);
    chk("data_rdata", bus.data_rdata_op & (e_dr ? msk : 32'hFFFF_FFFF), e_dr ? (e_rd & msk) : 32'd0);
  end

  task automatic txn(input bit dport, input bit we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    bit got;
    rd = '0; er = 0;
    @(posedge clk); #1;
    if (dport) begin d_req = 1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd; end
    else begin i_req = 1; i_addr = addr; end
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = dport ? bus.data_gnt_op : bus.instr_gnt_op;
    end
    chk("gnt_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (dport ? bus.data_rvalid_op : bus.instr_rvalid_op) begin
        got = 1;
        rd  = dport ? bus.data_rdata_op : bus.instr_rdata_op;
        er  = bus.err_op;
      end
    end
    chk("rvalid_wait", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [3:0] ord;
    int n;
`ifdef MEM_ACCESS_COUNTERS_EN
    logic [31:0] ic0;
`endif
    // Both ports requesting straight out of reset
    i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h20;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    ord = '0; n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      if (bus.data_gnt_op)  begin ord[n] = 1'b1; n++; end
      else if (bus.instr_gnt_op) begin ord[n] = 1'b0; n++; end
    end
    chk("rr_count", n, 4);
    chk("rr_order", {28'd0, ord}, {28'd0, 4'b0101});
    @(posedge clk); #1 i_req = 0; d_req = 0;
    repeat (4) @(posedge clk);

    // Preload word 5, then a timed fetch of it
    txn(1, 1, 4'hF, 32'h14, 32'hDEADBEEF, rd, er);
    chk("wr_resp_rdata", rd, 32'd0);
    @(posedge clk); #1 i_req = 1; i_addr = 32'h14;
    @(negedge clk);
    chk("t1_gnt_c0", bus.instr_gnt_op, 1);
    chk("t1_busy_c0", bus.busy_op, 1);
    @(posedge clk); #1 i_req = 0;
    @(negedge clk);
    chk("t1_rvalid_c1", bus.instr_rvalid_op, 0);
    chk("t1_busy_c1", bus.busy_op, 1);
    @(negedge clk);
    chk("t1_rvalid_c2", bus.instr_rvalid_op, 1);
    chk("t1_rdata_c2", bus.instr_rdata_op, 32'hDEADBEEF);
    chk("t1_busy_c2", bus.busy_op, 1);

    // Byte-enable merge
    txn(1, 1, 4'hF, 32'h20, 32'hAAAAAAAA, rd, er);
    txn(1, 1, 4'b0101, 32'h20, 32'h11223344, rd, er);
    chk("be_wr_rdata", rd, 32'd0);
    txn(1, 0, 4'h0, 32'h20, 32'h0, rd, er);
    chk("be_rd_rdata", rd, 32'hAA22AA44);
    chk("be_rd_err", 32'(er), 32'd0);
    txn(1, 1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er);
    txn(0, 0, 4'h0, 32'h20, 32'h0, rd, er);
    chk("be0_rdata", rd, 32'hAA22AA44);

    // Misaligned / out of range
    txn(1, 1, 4'hF, 32'h0, 32'h01020304, rd, er);
    txn(0, 0, 4'h0, 32'h3, 32'h0, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    txn(1, 0, 4'h0, 32'h400, 32'h0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    txn(1, 1, 4'hF, 32'h400, 32'h55555555, rd, er);
    chk("oor_wr_err", 32'(er), 32'd1);
    txn(1, 0, 4'h0, 32'h0, 32'h0, rd, er);
    chk("oor_wr_dropped", rd, 32'h01020304);

    // Reset during WAIT abandons a write
    txn(1, 1, 4'hF, 32'h24, 32'hCAFEF00D, rd, er);
    @(posedge clk); #1 d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h24; d_wdata = 32'h0BADBEEF;
    @(negedge clk);
    chk("rst_gnt", bus.data_gnt_op, 1);
    @(posedge clk); #1 d_req = 0; reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_rvalid", bus.data_rvalid_op, 0);
    chk("post_rst_busy", bus.busy_op, 0);
    repeat (3) @(posedge clk);
    txn(1, 0, 4'h0, 32'h24, 32'h0, rd, er);
    chk("rst_word_kept", rd, 32'hCAFEF00D);

    // mem_en gating
`ifdef MEM_ACCESS_COUNTERS_EN
    ic0 = c_instr;
`endif
    @(posedge clk); #1 mem_en = 0; i_req = 1; i_addr = 32'h14;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en0_gnt", bus.instr_gnt_op, 0);
    end
    @(posedge clk); #1 mem_en = 1;
    @(negedge clk);
    chk("en1_gnt", bus.instr_gnt_op, 1);
    @(posedge clk); #1 i_req = 0;
    repeat (4) @(posedge clk);
`ifdef MEM_ACCESS_COUNTERS_EN
    chk("instr_cnt", c_instr, ic0 + 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
